// File: rtl/nf10_axis_rx_meta_queue.sv
`default_nettype none
// nf10_axis_rx_meta_queue: store-and-forward 10G MAC receive queue that builds {dst,src,len} tuser metadata.
// Optional macro RX_META_STATS_EN enables the accepted/dropped frame counters. Revision 1.0
module nf10_axis_rx_meta_queue #(
   parameter int         C_AXIS_DATA_WIDTH    = 64,
   parameter int         C_M_AXIS_TUSER_WIDTH = 128,
   parameter int         C_FIFO_DEPTH_WORDS   = 512,
   parameter int         C_META_DEPTH         = 16,
   parameter logic [7:0] C_SRC_PORT           = 8'h01,
   parameter logic [7:0] C_DST_PORT           = 8'h00
) (
   input  logic                              axi_aclk,
   input  logic                              axi_resetn,
   input  logic [C_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
   input  logic [C_AXIS_DATA_WIDTH/8-1:0]    s_axis_tstrb,
   input  logic                              s_axis_tuser,
   input  logic                              s_axis_tvalid,
   output logic                              s_axis_tready,
   input  logic                              s_axis_tlast,
   output logic [C_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
   output logic [C_AXIS_DATA_WIDTH/8-1:0]    m_axis_tstrb,
   output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
   output logic                              m_axis_tvalid,
   input  logic                              m_axis_tready,
   output logic                              m_axis_tlast,
   output logic [31:0]                       stat_rx_pkts,
   output logic [31:0]                       stat_rx_drops
);

   localparam int C_STRB = C_AXIS_DATA_WIDTH / 8;
   localparam int AW     = $clog2(C_FIFO_DEPTH_WORDS);
   localparam int MAW    = $clog2(C_META_DEPTH);
   localparam int CW     = $clog2(C_STRB) + 1;
   localparam logic [AW:0]  DATA_FULL = {1'b1, {AW{1'b0}}};
   localparam logic [MAW:0] META_FULL = {1'b1, {MAW{1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_IN_PKT = 2'd1,
      S_DROP   = 2'd2
   } wr_state_t;

   logic [C_AXIS_DATA_WIDTH-1:0] data_mem [C_FIFO_DEPTH_WORDS];
   logic [C_STRB-1:0]            strb_mem [C_FIFO_DEPTH_WORDS];
   logic                         last_mem [C_FIFO_DEPTH_WORDS];
   logic [15:0]                  len_mem  [C_META_DEPTH];

   wr_state_t    wr_state;
   logic [AW:0]  wr_ptr;
   logic [AW:0]  wr_commit;
   logic [AW:0]  rd_ptr;
   logic [15:0]  len_acc;
   logic [MAW:0] meta_wr_ptr;
   logic [MAW:0] meta_rd_ptr;
   logic [MAW:0] meta_load_ptr;

   logic                         out_valid;
   logic                         out_last;
   logic [C_AXIS_DATA_WIDTH-1:0] out_data;
   logic [C_STRB-1:0]            out_strb;
   logic [31:0]                  out_tuser;
   logic                         ready_reg;

   function automatic logic [CW-1:0] popcount(input logic [C_STRB-1:0] v);
      logic [CW-1:0] n;
      n = '0;
      for (int i = 0; i < C_STRB; i++) begin
         n = n + CW'(v[i]);
      end
      return n;
   endfunction

   logic [15:0] len_base;
   logic [16:0] len_sum;
   logic [15:0] len_next;
   logic        data_full;
   logic        meta_full;
   logic        wr_active;
   logic        bad_end;
   logic        beat_write;
   logic        commit;
   logic        drop_evt;

   always_comb begin
      len_base   = (wr_state == S_IDLE) ? 16'd0 : len_acc;
      len_sum    = {1'b0, len_base} + 17'(popcount(s_axis_tstrb));
      len_next   = len_sum[16] ? 16'hFFFF : len_sum[15:0];
      data_full  = ((wr_ptr - rd_ptr) == DATA_FULL);
      meta_full  = ((meta_wr_ptr - meta_rd_ptr) == META_FULL);
      wr_active  = s_axis_tvalid && (wr_state != S_DROP);
      bad_end    = s_axis_tlast && (s_axis_tuser || meta_full);
      beat_write = wr_active && !data_full && !bad_end;
      commit     = beat_write && s_axis_tlast;
      drop_evt   = wr_active && (data_full || bad_end);
   end

   // Write side: uncommitted beats are rewound to wr_commit on any drop.
   always_ff @(posedge axi_aclk) begin
      if (!axi_resetn) begin
         wr_state    <= S_IDLE;
         wr_ptr      <= '0;
         wr_commit   <= '0;
         len_acc     <= '0;
         meta_wr_ptr <= '0;
         ready_reg   <= 1'b0;
      end else begin
         ready_reg <= 1'b1;
         if (beat_write) begin
            wr_ptr  <= wr_ptr + 1'b1;
            len_acc <= len_next;
         end else if (drop_evt) begin
            wr_ptr <= wr_commit;
         end
         if (commit) begin
            wr_commit   <= wr_ptr + 1'b1;
            meta_wr_ptr <= meta_wr_ptr + 1'b1;
         end
         if (s_axis_tvalid) begin
            case (wr_state)
               S_IDLE, S_IN_PKT: begin
                  if (s_axis_tlast)  wr_state <= S_IDLE;
                  else if (drop_evt) wr_state <= S_DROP;
                  else               wr_state <= S_IN_PKT;
               end
               S_DROP: begin
                  if (s_axis_tlast) wr_state <= S_IDLE;
               end
               default: wr_state <= S_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge axi_aclk) begin
      if (beat_write) begin
         data_mem[wr_ptr[AW-1:0]] <= s_axis_tdata;
         strb_mem[wr_ptr[AW-1:0]] <= s_axis_tstrb;
         last_mem[wr_ptr[AW-1:0]] <= s_axis_tlast;
      end
      if (commit) begin
         len_mem[meta_wr_ptr[MAW-1:0]] <= len_next;
      end
   end

   // Read side: meta_load_ptr tracks the frame being fetched into the output
   // register, meta_rd_ptr the frame still owning a metadata slot.
   logic frame_avail;
   logic out_fire;
   logic load;

   always_comb begin
      frame_avail = (meta_wr_ptr != meta_load_ptr);
      out_fire    = out_valid && m_axis_tready;
      load        = frame_avail && (!out_valid || m_axis_tready);
   end

   always_ff @(posedge axi_aclk) begin
      if (!axi_resetn) begin
         rd_ptr        <= '0;
         meta_rd_ptr   <= '0;
         meta_load_ptr <= '0;
         out_valid     <= 1'b0;
         out_last      <= 1'b0;
         out_data      <= '0;
         out_strb      <= '0;
         out_tuser     <= '0;
      end else begin
         if (out_fire && out_last) begin
            meta_rd_ptr <= meta_rd_ptr + 1'b1;
         end
         if (load) begin
            out_valid <= 1'b1;
            out_data  <= data_mem[rd_ptr[AW-1:0]];
            out_strb  <= strb_mem[rd_ptr[AW-1:0]];
            out_last  <= last_mem[rd_ptr[AW-1:0]];
            out_tuser <= {C_DST_PORT, C_SRC_PORT, len_mem[meta_load_ptr[MAW-1:0]]};
            rd_ptr    <= rd_ptr + 1'b1;
            if (last_mem[rd_ptr[AW-1:0]]) begin
               meta_load_ptr <= meta_load_ptr + 1'b1;
            end
         end else if (out_fire) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
      end
   end

   assign s_axis_tready = ready_reg;
   assign m_axis_tvalid = out_valid;
   assign m_axis_tlast  = out_last;
   assign m_axis_tdata  = out_data;
   assign m_axis_tstrb  = out_strb;

   generate
      if (C_M_AXIS_TUSER_WIDTH > 32) begin : g_tuser_pad
         assign m_axis_tuser = {{(C_M_AXIS_TUSER_WIDTH-32){1'b0}}, out_tuser};
      end else begin : g_tuser_exact
         assign m_axis_tuser = out_tuser;
      end
   endgenerate

`ifdef RX_META_STATS_EN
   logic [31:0] pkts_cnt;
   logic [31:0] drops_cnt;

   always_ff @(posedge axi_aclk) begin
      if (!axi_resetn) begin
         pkts_cnt  <= '0;
         drops_cnt <= '0;
      end else begin
         if (commit && (pkts_cnt != 32'hFFFF_FFFF))    pkts_cnt  <= pkts_cnt + 1'b1;
         if (drop_evt && (drops_cnt != 32'hFFFF_FFFF)) drops_cnt <= drops_cnt + 1'b1;
      end
   end

   assign stat_rx_pkts  = pkts_cnt;
   assign stat_rx_drops = drops_cnt;
`else
   assign stat_rx_pkts  = 32'd0;
   assign stat_rx_drops = 32'd0;
`endif

endmodule
`default_nettype wire
